// File: rtl/fetch_redirect_unit_if.sv
// Hazard inputs, instruction fetch data and IF/ID outputs of the fetch redirect unit.
// The slave modport is the unit itself; the master modport drives the hazard side.
interface fetch_redirect_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic              Stall;
  logic              Jump;
  logic [31:0]       JumpTarget;
  logic              no_branch;
  logic [31:0]       BranchTarget;
  logic [31:0]       Instruction;
  logic [31:0]       PC;
  logic [31:0]       IF_ID_PC;
  logic [31:0]       IF_ID_PCPlus4;
  logic [31:0]       IF_ID_Instruction;
  logic              IF_ID_Valid;
  logic [CNT_W-1:0]  RedirectCount;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output Stall, Jump, JumpTarget, no_branch, BranchTarget, Instruction,
    input  PC, IF_ID_PC, IF_ID_PCPlus4, IF_ID_Instruction, IF_ID_Valid,
           RedirectCount, StallCount
  );

  modport slave (
    input  Stall, Jump, JumpTarget, no_branch, BranchTarget, Instruction,
    output PC, IF_ID_PC, IF_ID_PCPlus4, IF_ID_Instruction, IF_ID_Valid,
           RedirectCount, StallCount
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Program counter and IF/ID register with branch/stall/jump priority handling.
// Also keeps saturating redirect and stall counters for performance debug.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_redirect_unit_if.slave  bus
);
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_if_id_pc;
  logic [XLEN-1:0]  r_if_id_pc_plus4;
  logic [XLEN-1:0]  r_if_id_instr;
  logic             r_if_id_valid;
  logic [CNT_W-1:0] r_redirect_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_branch;
  logic             w_stall;
  logic             w_jump;
  logic [XLEN-1:0]  w_pc_plus4;
  logic             w_unused_lsbs;

  // Exactly one action per cycle: branch beats stall beats jump beats sequential.
  assign w_branch      = ~bus.no_branch;
  assign w_stall       = bus.no_branch & bus.Stall;
  assign w_jump        = bus.no_branch & ~bus.Stall & bus.Jump;
  assign w_pc_plus4    = r_pc + XLEN'(4);
  assign w_unused_lsbs = ^{bus.JumpTarget[1:0], bus.BranchTarget[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc             <= RESET_PC;
      r_if_id_pc       <= '0;
      r_if_id_pc_plus4 <= '0;
      r_if_id_instr    <= '0;
      r_if_id_valid    <= 1'b0;
    end else if (w_branch) begin
      r_pc             <= {bus.BranchTarget[31:2], 2'b00};
      r_if_id_pc       <= '0;
      r_if_id_pc_plus4 <= '0;
      r_if_id_instr    <= '0;
      r_if_id_valid    <= 1'b0;
    end else if (w_jump) begin
      r_pc             <= {bus.JumpTarget[31:2], 2'b00};
      r_if_id_pc       <= '0;
      r_if_id_pc_plus4 <= '0;
      r_if_id_instr    <= '0;
      r_if_id_valid    <= 1'b0;
    end else if (!w_stall) begin
      r_pc             <= w_pc_plus4;
      r_if_id_pc       <= r_pc;
      r_if_id_pc_plus4 <= w_pc_plus4;
      r_if_id_instr    <= bus.Instruction;
      r_if_id_valid    <= 1'b1;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if ((w_branch || w_jump) && (r_redirect_cnt != '1)) begin
        r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.PC                = r_pc;
  assign bus.IF_ID_PC          = r_if_id_pc;
  assign bus.IF_ID_PCPlus4     = r_if_id_pc_plus4;
  assign bus.IF_ID_Instruction = r_if_id_instr;
  assign bus.IF_ID_Valid       = r_if_id_valid;
  assign bus.RedirectCount     = r_redirect_cnt;
  assign bus.StallCount        = r_stall_cnt;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed and randomized bench for fetch_redirect_unit against a behavioural pipeline model.
module tb_fetch_redirect_unit;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] RST_PC  = 32'h0040_0000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Model state: fetch address, ID-stage slot and the two event tallies.
  logic [31:0] m_pc, m_ifpc, m_ifp4, m_ifi;
  logic        m_valid;
  int          m_rc, m_sc;

  fetch_redirect_unit_if #(.CNT_W(CNT_W)) bus ();

  fetch_redirect_unit #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_ifpc = '0; m_ifp4 = '0; m_ifi = '0; m_valid = 1'b0;
    m_rc = 0; m_sc = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    bus.PC,                m_pc);
    check({tag, ".ifpc"},  bus.IF_ID_PC,          m_ifpc);
    check({tag, ".ifp4"},  bus.IF_ID_PCPlus4,     m_ifp4);
    check({tag, ".ifi"},   bus.IF_ID_Instruction, m_ifi);
    check({tag, ".valid"}, 32'(bus.IF_ID_Valid),  32'(m_valid));
    check({tag, ".rc"},    32'(bus.RedirectCount), 32'(m_rc));
    check({tag, ".sc"},    32'(bus.StallCount),    32'(m_sc));
  endtask

  task automatic check_reset_consts(input string tag);
    check({tag, ".pc"},    bus.PC,                 RST_PC);
    check({tag, ".ifpc"},  bus.IF_ID_PC,           32'h0);
    check({tag, ".ifp4"},  bus.IF_ID_PCPlus4,      32'h0);
    check({tag, ".ifi"},   bus.IF_ID_Instruction,  32'h0);
    check({tag, ".valid"}, 32'(bus.IF_ID_Valid),   32'h0);
    check({tag, ".rc"},    32'(bus.RedirectCount), 32'h0);
    check({tag, ".sc"},    32'(bus.StallCount),    32'h0);
  endtask

  // One clock: drive hazards, fetch data is the model PC pattern, then advance model and compare.
  task automatic step(input string tag, input logic st, input logic jp, input logic [31:0] jt,
                      input logic nb, input logic [31:0] bt);
    logic [31:0] instr;
    instr = m_pc ^ 32'hA5A5_0000;
    bus.Stall = st; bus.Jump = jp; bus.JumpTarget = jt;
    bus.no_branch = nb; bus.BranchTarget = bt; bus.Instruction = instr;
    @(posedge clk);
    if (!nb) begin
      m_pc = bt & ~32'h3;
      m_ifpc = '0; m_ifp4 = '0; m_ifi = '0; m_valid = 1'b0;
      if (m_rc < CNT_MAX) m_rc++;
    end else if (st) begin
      if (m_sc < CNT_MAX) m_sc++;
    end else if (jp) begin
      m_pc = jt & ~32'h3;
      m_ifpc = '0; m_ifp4 = '0; m_ifi = '0; m_valid = 1'b0;
      if (m_rc < CNT_MAX) m_rc++;
    end else begin
      m_ifpc = m_pc; m_ifp4 = m_pc + 32'd4; m_ifi = instr; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    #1;
    check_all(tag);
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
  endtask

  initial begin
    checks = 0; errors = 0;
    bus.Stall = 1'b0; bus.Jump = 1'b0; bus.JumpTarget = '0;
    bus.no_branch = 1'b1; bus.BranchTarget = '0; bus.Instruction = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2 check_reset_consts("rst");
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // Sequential fetch from reset.
    seq("seq0"); check("seq0.pc_abs", bus.PC, 32'h0040_0004);
    check("seq0.ifpc_abs", bus.IF_ID_PC, 32'h0040_0000);
    check("seq0.ifi_abs", bus.IF_ID_Instruction, 32'h0040_0000 ^ 32'hA5A5_0000);
    seq("seq1"); check("seq1.pc_abs", bus.PC, 32'h0040_0008);
    seq("seq2"); check("seq2.pc_abs", bus.PC, 32'h0040_000C);
    seq("seq3"); check("seq3.pc_abs", bus.PC, 32'h0040_0010);

    // Jump with misaligned target.
    step("jmp", 1'b0, 1'b1, 32'h0040_0103, 1'b1, 32'h0);
    check("jmp.pc_abs", bus.PC, 32'h0040_0100);
    check("jmp.valid_abs", 32'(bus.IF_ID_Valid), 32'h0);
    check("jmp.rc_abs", 32'(bus.RedirectCount), 32'h1);
    seq("jmp_next"); check("jmp_next.ifpc_abs", bus.IF_ID_PC, 32'h0040_0100);

    // Branch overrides stall and jump.
    step("brall", 1'b1, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0200);
    check("brall.pc_abs", bus.PC, 32'h0040_0200);
    check("brall.rc_abs", 32'(bus.RedirectCount), 32'h2);
    check("brall.sc_abs", 32'(bus.StallCount), 32'h0);
    seq("brall_next");

    // Stall holds a pending jump, which then fires.
    step("stj0", 1'b1, 1'b1, 32'h0040_0500, 1'b1, 32'h0);
    step("stj1", 1'b1, 1'b1, 32'h0040_0500, 1'b1, 32'h0);
    check("stj1.sc_abs", 32'(bus.StallCount), 32'h2);
    step("stj2", 1'b0, 1'b1, 32'h0040_0500, 1'b1, 32'h0);
    check("stj2.pc_abs", bus.PC, 32'h0040_0500);
    check("stj2.rc_abs", 32'(bus.RedirectCount), 32'h3);

    // PC wraps past the top of the address space.
    step("wrapj", 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h0);
    check("wrapj.pc_abs", bus.PC, 32'hFFFF_FFFC);
    seq("wrap");
    check("wrap.pc_abs", bus.PC, 32'h0000_0000);
    check("wrap.ifp4_abs", bus.IF_ID_PCPlus4, 32'h0000_0000);

    // Long stall saturates the stall counter.
    for (int i = 0; i < 20; i++) step("satst", 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    check("sat.sc_abs", 32'(bus.StallCount), 32'hF);

    // Asynchronous reset between edges during a stall.
    step("prerst", 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    #2 reset = 1'b1;
    #1 check_reset_consts("arst");
    #1 reset = 1'b0;
    model_reset();
    seq("post_rst");

    // Randomized hazard mix.
    for (int i = 0; i < 300; i++) begin
      logic st, jp, nb;
      logic [31:0] jt, bt;
      st = ($urandom_range(0, 3) == 0);
      jp = ($urandom_range(0, 4) == 0);
      nb = ($urandom_range(0, 5) != 0);
      jt = $urandom;
      bt = $urandom;
      step("rnd", st, jp, jt, nb, bt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
